// File: rtl/arb_pkg.sv
// arb_pkg: shared types and default sizing for the request arbiter.
package arb_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_t;
  localparam int ARB_N        = 8;
  localparam int ARB_MAX_HOLD = 16;
endpackage

// File: rtl/rot_priority_pick.sv
// rot_priority_pick: highest-index-wins pick, optionally rotated so the search starts just below base.
module rot_priority_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] base_i,
  input  logic             rot_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);
  logic [IDX_W-1:0] eff_base;
  assign eff_base = rot_i ? base_i : '0;
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int j = 0; j < N; j++)
      if (req_i[IDX_W'(j) + eff_base]) begin
        idx_o   = IDX_W'(j) + eff_base;
        found_o = 1'b1;
      end
  end
endmodule

// File: rtl/req_arbiter_ctrl.sv
// req_arbiter_ctrl: fixed/round-robin arbiter with held grants, hold timeout and a dead cycle between owners.
module req_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout_pulse
);
  localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  arb_state_t       state_q;
  logic [N-1:0]     gnt_q;
  logic [IDX_W-1:0] idx_q, last_q, win;
  logic [CNT_W-1:0] hold_q;
  logic             valid_q, to_q, found, expired;
  rot_priority_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req_i  (req),
    .base_i (last_q),
    .rot_i  (arb_mode_t'(mode) == ARB_RR),
    .idx_o  (win),
    .found_o(found)
  );
  assign expired = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD));
  // Release and timeout share one exit; the pulse fires only when the owner still wanted the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      if (state_q == IDLE) begin
        if (found) begin
          state_q <= BUSY;
          gnt_q   <= N'(1) << win;
          idx_q   <= win;
          last_q  <= win;
          hold_q  <= CNT_W'(1);
          valid_q <= 1'b1;
        end
      end else if (!req[idx_q] || expired) begin
        state_q <= IDLE;
        gnt_q   <= '0;
        idx_q   <= '0;
        hold_q  <= '0;
        valid_q <= 1'b0;
        to_q    <= req[idx_q];
      end else if (MAX_HOLD != 0 && !expired) begin
        hold_q <= hold_q + CNT_W'(1);
      end
    end
  end
  assign gnt           = gnt_q;
  assign gnt_idx       = idx_q;
  assign gnt_valid     = valid_q;
  assign timeout_pulse = to_q;
endmodule

// File: tb/tb_req_arbiter_ctrl.sv
// tb_req_arbiter_ctrl: directed table plus hand sequences for reset, rotation, timeout and collision cases.
module tb_req_arbiter_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, mode = 1'b0;
  logic [7:0] req = '0, req0 = '0, gnt, gnt0;
  logic [2:0] gnt_idx, gnt_idx0;
  logic       gnt_valid, gnt_valid0, to, to0;
  int         checks = 0, errors = 0;
  typedef struct packed {
    logic       m;
    logic [7:0] r;
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
  } vec_t;
  vec_t tbl[19];
  always #5 clk = ~clk;
  req_arbiter_ctrl #(.N(8), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout_pulse(to)
  );
  req_arbiter_ctrl #(.N(8), .MAX_HOLD(0)) u_nohold (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req0),
    .gnt(gnt0), .gnt_idx(gnt_idx0), .gnt_valid(gnt_valid0), .timeout_pulse(to0)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string name, input logic [7:0] g, input logic [2:0] i, input logic t);
    chk(name, {3'b0, gnt, gnt_idx, gnt_valid, to}, {3'b0, g, i, |g, t});
  endtask
  initial begin
    tbl[0]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 8'h24, 8'h20, 3'd5, 1'b1};
    tbl[2]  = '{1'b0, 8'h24, 8'h20, 3'd5, 1'b1};
    tbl[3]  = '{1'b0, 8'h04, 8'h00, 3'd0, 1'b0};
    tbl[4]  = '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
    tbl[6]  = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b1};
    tbl[7]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
    tbl[8]  = '{1'b1, 8'hA4, 8'h04, 3'd2, 1'b1};
    tbl[9]  = '{1'b1, 8'hA0, 8'h00, 3'd0, 1'b0};
    tbl[10] = '{1'b1, 8'hA0, 8'h80, 3'd7, 1'b1};
    tbl[11] = '{1'b1, 8'h20, 8'h00, 3'd0, 1'b0};
    tbl[12] = '{1'b1, 8'h24, 8'h20, 3'd5, 1'b1};
    tbl[13] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
    tbl[14] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
    tbl[15] = '{1'b1, 8'h0F, 8'h01, 3'd0, 1'b1};
    tbl[16] = '{1'b0, 8'h81, 8'h01, 3'd0, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
    tbl[18] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("reset_idle", 8'h00, 3'd0, 1'b0);
    req = 8'h24;
    tick();
    chk_out("pre_reset_grant", 8'h20, 3'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("async_reset_drop", 8'h00, 3'd0, 1'b0);
    req = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("post_reset_idle", 8'h00, 3'd0, 1'b0);
    for (int k = 0; k < 19; k++) begin
      mode = tbl[k].m;
      req  = tbl[k].r;
      tick();
      chk($sformatf("vec%0d", k), {3'b0, gnt, gnt_idx, gnt_valid, to},
          {3'b0, tbl[k].g, tbl[k].i, tbl[k].v, 1'b0});
    end
    // last_idx is 0 here: RR search starts at 7, so idx 3 wins first
    mode = 1'b1;
    req  = 8'h0A;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("timeout_hold%0d", k), {3'b0, gnt, gnt_idx, gnt_valid, to}, {3'b0, 8'h08, 3'd3, 1'b1, 1'b0});
    end
    tick();
    chk_out("timeout_pulse", 8'h00, 3'd0, 1'b1);
    tick();
    chk_out("timeout_next_grant", 8'h02, 3'd1, 1'b0);
    req = 8'h00;
    tick();
    chk_out("timeout_release", 8'h00, 3'd0, 1'b0);
    mode = 1'b0;
    req  = 8'h01;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("collide_hold%0d", k), {3'b0, gnt, gnt_idx, gnt_valid, to}, {3'b0, 8'h01, 3'd0, 1'b1, 1'b0});
    end
    req = 8'h00;
    tick();
    chk_out("collide_release_wins", 8'h00, 3'd0, 1'b0);
    tick();
    chk_out("collide_no_late_pulse", 8'h00, 3'd0, 1'b0);
    req0 = 8'h01;
    for (int k = 0; k < 100; k++) begin
      tick();
      chk($sformatf("nohold%0d", k), {3'b0, gnt0, gnt_idx0, gnt_valid0, to0}, {3'b0, 8'h01, 3'd0, 1'b1, 1'b0});
    end
    req0 = 8'h00;
    tick();
    chk("nohold_release", {3'b0, gnt0, gnt_idx0, gnt_valid0, to0}, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
